// File: rtl/microwave_controller_p.sv
// Microwave controller: BCD keypad time entry, mm:ss countdown with power-level
// duty cycle, pause/resume, door interlock and a timed done indication.
module microwave_controller_p #(
    parameter int CLK_PER_SEC = 1000,
    parameter int MIN_DIGITS  = 1,
    parameter int DONE_SECS   = 3
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic [9:0]                  keypad,
    input  logic                        startn,
    input  logic                        stopn,
    input  logic                        clearn,
    input  logic                        powern,
    input  logic                        door_closed,
    output logic                        mag_on,
    output logic                        cooking,
    output logic                        done,
    output logic [7*(2+MIN_DIGITS)-1:0] seg
);
    localparam int ND = 2 + MIN_DIGITS;
    localparam int PW = $clog2(CLK_PER_SEC);
    localparam int DW = $clog2(DONE_SECS + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);
    localparam logic [DW-1:0] DONE_LAST  = DW'(DONE_SECS - 1);

    typedef enum logic [1:0] {S_IDLE, S_COOK, S_PAUSED, S_DONE} state_t;
    typedef logic [ND-1:0][3:0] time_t;

    state_t        state_q, state_d;
    time_t         time_q, time_d, time_dec;
    logic [3:0]    power_q, power_d;
    logic [3:0]    win_q, win_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    logic [9:0] key_s_q, key_p_q;
    logic       start_s_q, start_p_q, stop_s_q, stop_p_q, clear_s_q, clear_p_q;
    logic       power_s_q, door_s_q;

    logic       key_ev, start_ev, stop_ev, clear_ev, halt, tick, time_nz;
    logic [3:0] key_digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // Seconds tens wraps to 5, so entered tens digits 6-9 simply count down.
    function automatic time_t dec_time(input time_t t);
        time_t r;
        logic  borrow;
        r      = t;
        borrow = 1'b0;
        if (t[0] != 4'd0) begin
            r[0] = t[0] - 4'd1;
        end else begin
            r[0] = 4'd9;
            if (t[1] != 4'd0) begin
                r[1] = t[1] - 4'd1;
            end else begin
                r[1]   = 4'd5;
                borrow = 1'b1;
                for (int i = 2; i < ND; i++) begin
                    if (borrow) begin
                        if (t[i] != 4'd0) begin
                            r[i]   = t[i] - 4'd1;
                            borrow = 1'b0;
                        end else begin
                            r[i] = 4'd9;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            key_s_q   <= '0;
            key_p_q   <= '0;
            start_s_q <= 1'b1;
            start_p_q <= 1'b1;
            stop_s_q  <= 1'b1;
            stop_p_q  <= 1'b1;
            clear_s_q <= 1'b1;
            clear_p_q <= 1'b1;
            power_s_q <= 1'b1;
            door_s_q  <= 1'b0;
        end else begin
            key_s_q   <= keypad;
            key_p_q   <= key_s_q;
            start_s_q <= startn;
            start_p_q <= start_s_q;
            stop_s_q  <= stopn;
            stop_p_q  <= stop_s_q;
            clear_s_q <= clearn;
            clear_p_q <= clear_s_q;
            power_s_q <= powern;
            door_s_q  <= door_closed;
        end
    end

    assign key_ev   = (key_s_q != 10'd0) && ((key_s_q & (key_s_q - 10'd1)) == 10'd0)
                      && ((key_s_q & ~key_p_q) != 10'd0);
    assign start_ev = start_p_q & ~start_s_q;
    assign stop_ev  = stop_p_q & ~stop_s_q;
    assign clear_ev = clear_p_q & ~clear_s_q;
    assign halt     = stop_ev | ~door_s_q;
    assign tick     = (presc_q == PRESC_LAST);
    assign time_nz  = (time_q != '0);
    assign time_dec = dec_time(time_q);

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_s_q[i]) key_digit = 4'(i);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Priority: clear, then door-open/stop, then start.
    always_comb begin
        state_d = state_q;
        if (clear_ev) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start_ev && door_s_q && time_nz) state_d = S_COOK;
                S_COOK: begin
                    if (halt)                                 state_d = S_PAUSED;
                    else if (tick && (time_dec == '0))        state_d = S_DONE;
                end
                S_PAUSED: if (!halt && start_ev && time_nz)  state_d = S_COOK;
                S_DONE:   if (tick && (dcnt_q == DONE_LAST)) state_d = S_IDLE;
                default:                                      state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        time_d  = time_q;
        power_d = power_q;
        win_d   = win_q;
        presc_d = presc_q;
        dcnt_d  = dcnt_q;
        if (clear_ev) begin
            time_d  = '0;
            power_d = 4'd10;
            win_d   = 4'd0;
            presc_d = '0;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ev && door_s_q && time_nz) begin
                        presc_d = '0;
                        win_d   = 4'd0;
                    end else if (key_ev) begin
                        if (power_s_q) time_d  = {time_q[ND-2:0], key_digit};
                        else           power_d = (key_digit == 4'd0) ? 4'd10 : key_digit;
                    end
                end
                S_COOK: begin
                    if (!halt) begin
                        if (tick) begin
                            presc_d = '0;
                            win_d   = (win_q == 4'd9) ? 4'd0 : win_q + 4'd1;
                            time_d  = time_dec;
                            dcnt_d  = '0;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (tick) begin
                        presc_d = '0;
                        dcnt_d  = dcnt_q + DW'(1);
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            time_q  <= '0;
            power_q <= 4'd10;
            win_q   <= 4'd0;
            presc_q <= '0;
            dcnt_q  <= '0;
        end else begin
            time_q  <= time_d;
            power_q <= power_d;
            win_q   <= win_d;
            presc_q <= presc_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Raw door input gates the magnetron so opening the door cuts it at once.
    always_comb begin
        cooking = (state_q == S_COOK);
        done    = (state_q == S_DONE);
        mag_on  = (state_q == S_COOK) && (win_q < power_q) && door_closed;
        seg     = '0;
        for (int i = 0; i < ND; i++) begin
            seg[7*i +: 7] = seg7(time_q[i]);
        end
    end
endmodule

// File: doc/microwave_controller_p.md
# microwave_controller_p

Parametrised next-generation microwave controller. Captures keypad time entry in BCD and counts down in minutes:seconds with configurable minute-digit count and tick rate. Adds a power-level duty cycle, pause/resume, a door interlock and a timed "done" indication. Drives the magnetron enable and one seven-segment pattern per displayed digit; sits directly behind the front-panel key/door inputs.

## Interface
- CLK_PER_SEC, 1000: clock cycles per one-second tick, ≥2.
- MIN_DIGITS, 1: number of minute digits, 1 or 2.
- DONE_SECS, 3: seconds `done` stays high after countdown ends, ≥1.
- ND (derived, not overridable) = 2 + MIN_DIGITS.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- keypad  in  10  one-hot digit keys; bit d = digit d.
- startn  in  1  start key, active-low.
- stopn  in  1  stop/pause key, active-low.
- clearn  in  1  clear key, active-low.
- powern  in  1  power-set modifier, active-low level.
- door_closed  in  1  1 = door closed.
- mag_on  out  1  magnetron enable.
- cooking  out  1  high in COOK.
- done  out  1  end-of-cook indication.
- seg  out  7*ND  digit i at [7i+6:7i]; i=0 seconds ones, 1 seconds tens, 2.. minutes (ascending significance).

## Operation
- Every key input passes through one sampling flop; an event is the sampled value differing from its previous sample (keypad rising edge, startn/stopn/clearn falling edge). A keypad event counts only if the sampled keypad is exactly one-hot; zero or multiple bits are ignored.
- States: IDLE, COOK, PAUSED, DONE.
- IDLE, keypad event d, powern high: time digits shift left one place, d enters digit 0, the top digit is discarded.
- IDLE, keypad event d, powern low: power level = d, except d=0 gives 10; time unchanged.
- IDLE or PAUSED, start event, door_closed=1, time≠0 → COOK. From IDLE, prescaler and duty window clear to 0; from PAUSED, both resume from held values. Start with time=0 or door open is ignored.
- COOK: each tick (prescaler reaching CLK_PER_SEC−1, then wrap to 0) decrements the time. If ones>0, ones−1; otherwise ones=9, and if tens>0, tens−1; otherwise tens=5 and minutes decrement in BCD. Entered tens digits 6–9 are legal (0:90 counts 0:89…).
- The duty window counter (0..9) advances on each tick and wraps 9→0.
- If the decrement reaches all-zero → DONE.
- COOK: stop event or door_closed=0 → PAUSED. Time, prescaler and window are held.
- DONE: done=1, time=0, prescaler counts; after DONE_SECS ticks → IDLE, done=0.
- Clear event in any state: time=0, power=10, done=0, → IDLE.
- Priority on the same cycle: clear > door-open/stop > start. Keypad events outside IDLE are ignored.
- mag_on = (state==COOK) & (window < power) & door_closed. Combinational door gating is required; mag_on is never high with the door open.
- cooking = (state==COOK), registered.
- seg encoding, active-high, bit0=a..bit6=g: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Leading zeros are displayed.

## Timing
- Reset values: state IDLE, time 0, power 10, prescaler and window 0, mag_on 0, cooking 0, done 0, every seg digit 7'h3F.
- Event latency: an input change captured at edge k causes the state/time update at edge k+1.
- First tick after IDLE→COOK comes CLK_PER_SEC cycles after the COOK entry edge; later ticks follow every CLK_PER_SEC cycles.
- The seg update is visible at the same edge as the time register.
- Door opening drops mag_on in the same cycle (combinational); cooking falls at edge k+1.
- Reset asserted mid-cook: all outputs return to reset values immediately.

## Test plan
- Reset, MIN_DIGITS=1: seg = 3F,3F,3F; mag_on=0, cooking=0, done=0.
- CLK_PER_SEC=4: keys 1,4,0 then start → seg shows 1:40, cooking=1 and mag_on=1 two edges after startn falls. After 4 cycles → 1:39. After 41 ticks → 0:59.
- Enter 2, start → 0:01 then 0:00 → done=1 for DONE_SECS×4 cycles, mag_on=0, then IDLE.
- powern low + key 3, then enter 2,0, start → mag_on high for ticks 0–2 and low for ticks 3–9 of each 10-tick window. The countdown is unaffected.
- Door opened mid-cook → mag_on=0 in the same cycle; state PAUSED; display frozen. Door closed + start → resumes from the held time and window.
- clearn and startn fall together in PAUSED → IDLE, time 0:00, power 10, mag_on=0.
